// File: rtl/sm_key_ctrl.sv
// Board key front end: synchronizes and debounces the two raw keys, turns KEY0
// into run/step control of the core clock enable and KEY1 into a display register select.
module sm_key_ctrl #(
  parameter int         DB_CYCLES   = 1000000,
  parameter int         LONG_CYCLES = 100000000,
  parameter logic [4:0] REG_DEFAULT = 5'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] keyRaw,
  output logic [1:0] keyLevel,
  output logic [1:0] keyPress,
  output logic [1:0] keyRelease,
  output logic       runMode,
  output logic       clkEnable,
  output logic [4:0] regAddr
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  // The long-press decision is taken on the edge where the hold count would reach LONG_CYCLES-1.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 2);

  typedef enum logic [1:0] {K_IDLE, K_HELD, K_LONG} key_state_t;

  logic [1:0]        r_sync1;
  logic [1:0]        r_sync2;
  logic [DB_W-1:0]   r_db_cnt [2];
  key_state_t        r_state;
  logic [HOLD_W-1:0] r_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= ~keyRaw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: press/release pulses are raised on the same edge that updates keyLevel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
      keyLevel    <= 2'b00;
      keyPress    <= 2'b00;
      keyRelease  <= 2'b00;
    end else begin
      keyPress   <= 2'b00;
      keyRelease <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == keyLevel[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i]   <= '0;
          keyLevel[i]   <= r_sync2[i];
          keyPress[i]   <= r_sync2[i];
          keyRelease[i] <= ~r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // clkEnable follows runMode one cycle late; a short release in step mode forces a single pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= K_IDLE;
      r_hold    <= '0;
      runMode   <= 1'b1;
      clkEnable <= 1'b1;
    end else begin
      clkEnable <= runMode;
      unique case (r_state)
        K_IDLE: begin
          if (keyPress[0]) begin
            r_state <= K_HELD;
            r_hold  <= '0;
          end
        end
        K_HELD: begin
          if (keyRelease[0]) begin
            r_state <= K_IDLE;
            if (!runMode) clkEnable <= 1'b1;
          end else if (r_hold == HOLD_LAST) begin
            r_state <= K_LONG;
            runMode <= ~runMode;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        K_LONG: begin
          if (keyRelease[0]) r_state <= K_IDLE;
        end
        default: r_state <= K_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regAddr <= REG_DEFAULT;
    end else if (keyPress[1]) begin
      regAddr <= regAddr + 5'd1;
    end
  end

endmodule

// File: tb/tb_sm_key_ctrl.sv
// Bench for sm_key_ctrl: directed timing scenarios plus randomized key activity,
// every cycle compared against a time-stamp based behavioural model.
module tb_sm_key_ctrl;
  localparam int DB   = 4;
  localparam int LONG = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] keyRaw = 2'b11;
  logic [1:0] keyLevel, keyPress, keyRelease;
  logic       runMode, clkEnable;
  logic [4:0] regAddr;

  sm_key_ctrl #(.DB_CYCLES(DB), .LONG_CYCLES(LONG), .REG_DEFAULT(5'd2)) dut (
    .clk(clk), .rst(rst), .keyRaw(keyRaw), .keyLevel(keyLevel),
    .keyPress(keyPress), .keyRelease(keyRelease), .runMode(runMode),
    .clkEnable(clkEnable), .regAddr(regAddr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: keys seen two cycles late, a level flips after DB consecutive
  // differing cycles, and KEY0 long/short is decided from the press time stamp.
  logic [1:0] m_d1, m_d2, m_level, m_press, m_rel;
  int         m_run [2];
  logic       m_holding, m_long, m_rm, m_ce;
  logic [4:0] m_reg;
  int         m_cyc = 0;
  int         m_t_press = 0;

  task automatic m_reset();
    m_d1 = 2'b00; m_d2 = 2'b00; m_level = 2'b00; m_press = 2'b00; m_rel = 2'b00;
    m_run[0] = 0; m_run[1] = 0;
    m_holding = 1'b0; m_long = 1'b0; m_rm = 1'b1; m_ce = 1'b1; m_reg = 5'd2;
  endtask

  task automatic m_step();
    logic [1:0] pv_press, pv_rel, nw_press, nw_rel;
    logic step;
    pv_press = m_press; pv_rel = m_rel;
    nw_press = 2'b00; nw_rel = 2'b00; step = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (m_d2[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_level[i] = m_d2[i];
          if (m_d2[i]) nw_press[i] = 1'b1;
          else         nw_rel[i]   = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = ~keyRaw;
    if (pv_press[0]) begin
      m_t_press = m_cyc; m_holding = 1'b1; m_long = 1'b0;
    end else if (m_holding && pv_rel[0]) begin
      if (!m_long && !m_rm) step = 1'b1;
      m_holding = 1'b0; m_long = 1'b0;
    end
    m_ce = m_rm | step;
    if (m_holding && !m_long && (m_cyc - m_t_press == LONG - 1)) begin
      m_long = 1'b1;
      m_rm   = ~m_rm;
    end
    if (pv_press[1]) m_reg = m_reg + 5'd1;
    m_press = nw_press;
    m_rel   = nw_rel;
    m_cyc++;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_reset();
    end else begin
      m_step();
      check("keyLevel",   int'(keyLevel),   int'(m_level));
      check("keyPress",   int'(keyPress),   int'(m_press));
      check("keyRelease", int'(keyRelease), int'(m_rel));
      check("runMode",    int'(runMode),    int'(m_rm));
      check("clkEnable",  int'(clkEnable),  int'(m_ce));
      check("regAddr",    int'(regAddr),    int'(m_reg));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int n, pulses, rel_at, ce_at, seen;

    // Asynchronous reset with no clock edge in between
    #1 rst = 1'b1;
    #2;
    check("rst_keyLevel", int'(keyLevel), 0);
    check("rst_runMode", int'(runMode), 1);
    check("rst_clkEnable", int'(clkEnable), 1);
    check("rst_regAddr", int'(regAddr), 2);
    cyc(); cyc();
    rst = 1'b0;
    repeat (3) cyc();

    // Bounce on KEY1 is rejected, then a clean press
    keyRaw = 2'b01;
    seen = 0;
    repeat (3) begin cyc(); if (keyPress[1]) seen++; end
    keyRaw = 2'b11;
    repeat (10) begin cyc(); if (keyPress[1]) seen++; end
    check("bounce_press", seen, 0);
    check("bounce_regAddr", int'(regAddr), 2);
    keyRaw = 2'b01;
    n = 0;
    do begin cyc(); n++; end while (!keyLevel[1] && n < 40);
    check("press_latency", n, 6);
    check("press_pulse", int'(keyPress[1]), 1);
    repeat (4) cyc();
    keyRaw = 2'b11;
    repeat (10) cyc();
    check("press_regAddr", int'(regAddr), 3);

    // Wrap of the register select
    pulse_reset();
    for (int k = 0; k < 30; k++) begin
      keyRaw = 2'b01;
      repeat (8) cyc();
      keyRaw = 2'b11;
      repeat (8) cyc();
      check("wrap_regAddr", int'(regAddr), (3 + k) % 32);
    end

    // Long press switches to single-step mode without a pulse
    keyRaw = 2'b10;
    n = 0;
    do begin cyc(); n++; end while (!keyPress[0] && n < 40);
    check("long_press_seen", int'(keyPress[0]), 1);
    n = 0;
    do begin cyc(); n++; end while (runMode && n < 60);
    check("long_toggle_delay", n, 20);
    cyc();
    check("long_ce_off", int'(clkEnable), 0);
    repeat (3) cyc();
    keyRaw = 2'b11;
    pulses = 0;
    repeat (15) begin cyc(); if (clkEnable) pulses++; end
    check("long_release_pulses", pulses, 0);
    check("long_runMode", int'(runMode), 0);

    // Short press in step mode gives exactly one enable pulse
    keyRaw = 2'b10;
    pulses = 0; rel_at = -100; ce_at = -200;
    for (int c = 0; c < 30; c++) begin
      if (c == 8) keyRaw = 2'b11;
      cyc();
      if (keyRelease[0]) rel_at = c;
      if (clkEnable) begin pulses++; ce_at = c; end
    end
    check("step_pulses", pulses, 1);
    check("step_pulse_pos", ce_at - rel_at, 1);
    check("step_runMode", int'(runMode), 0);

    // Reset while KEY0 is held discards the press
    keyRaw = 2'b10;
    n = 0;
    do begin cyc(); n++; end while (!keyPress[0] && n < 40);
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    check("midrst_runMode", int'(runMode), 1);
    check("midrst_clkEnable", int'(clkEnable), 1);
    check("midrst_keyLevel", int'(keyLevel), 0);
    cyc(); cyc();
    rst = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (!keyPress[0] && n < 40);
    check("midrst_repress", n, 6);
    keyRaw = 2'b11;
    repeat (12) cyc();
    check("midrst_runMode_after", int'(runMode), 1);

    // Randomized key activity, including occasional resets
    for (int seg = 0; seg < 220; seg++) begin
      keyRaw = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 30)) cyc();
      if ($urandom_range(0, 40) == 0) pulse_reset();
    end
    keyRaw = 2'b11;
    repeat (20) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
